rr_moore_arbiter: RTL and testbench



---
 rtl/rr_moore_arbiter.sv | 116 +++++++++++
 tb/tb_rr_moore_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_moore_arbiter.sv
// Moore round-robin arbiter: bounded grant window followed by a one-cycle release gap.
// Optional ARB_PRIO0_EN gives requester 0 priority without breaking rotation for the others.
module rr_moore_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 2,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_start,
    output logic            busy
);

    // state | meaning
    // IDLE  | no owner, scanning for requests
    // GRANT | owner holds the resource, cnt counts grant cycles
    // REST  | one-cycle release gap, ptr advances past owner
    typedef enum logic [1:0] {IDLE, GRANT, REST} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt, ptr_rest;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [IDW-1:0]  scan_base, scan_idx;
    logic [NREQ-1:0] scan_req;
    logic            scan_hit;
    int              best_off, off;

    always_comb begin
        ptr_rest = (owner == IDW'(NREQ-1)) ? '0 : owner + 1'b1;
`ifdef ARB_PRIO0_EN
        if (owner == '0) ptr_rest = ptr;
`endif
    end

    always_comb begin
        scan_req  = req;
        scan_base = (state == REST) ? ptr_rest : ptr;
`ifdef ARB_PRIO0_EN
        // right after its own grant, requester 0 yields once so the others keep rotating
        if (state == REST && owner == '0 && |req[NREQ-1:1]) scan_req[0] = 1'b0;
`endif
        best_off = NREQ;
        off      = 0;
        scan_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            off = (j - int'(scan_base) + NREQ) % NREQ;
            if (scan_req[j] && off < best_off) begin
                best_off = off;
                scan_idx = IDW'(j);
            end
        end
`ifdef ARB_PRIO0_EN
        if (scan_req[0]) scan_idx = '0;
`endif
        scan_hit = |scan_req;
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (scan_hit) begin
                    state_nxt = GRANT;
                    owner_nxt = scan_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (cnt == 4'(HOLD-1) || done || !req[owner]) state_nxt = REST;
                else cnt_nxt = cnt + 4'd1;
            end
            REST: begin
                ptr_nxt = ptr_rest;
                if (scan_hit) begin
                    state_nxt = GRANT;
                    owner_nxt = scan_idx;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // outputs decode from registered state only
    always_comb begin
        gnt       = (state == GRANT) ? (NREQ'(1) << owner) : '0;
        gnt_id    = owner;
        gnt_start = (state == GRANT) && (cnt == 4'd0);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_rr_moore_arbiter.sv
// Directed self-checking bench for rr_moore_arbiter (NREQ=4, HOLD=2).
// Build with ARB_PRIO0_EN defined to exercise the requester-0 priority sequence.
module tb_rr_moore_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b1111;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_start;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    rr_moore_arbiter #(.NREQ(4), .HOLD(2), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_start (gnt_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rot_seq [5];
        logic [3:0] prio_seq [6];
        rot_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prio_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000};

        // reset held with all requests
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_start", 32'(gnt_start), 32'h0);
        end
        check("rst_id", 32'(gnt_id), 32'h0);
        reset = 1'b0;
        step(1);
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_start", 32'(gnt_start), 32'h1);

        // single continuous requester 2
        do_reset();
        req = 4'b0100;
        step(1);
        check("r2_g0", 32'(gnt), 32'h4);
        check("r2_s0", 32'(gnt_start), 32'h1);
        check("r2_id0", 32'(gnt_id), 32'h2);
        step(1);
        check("r2_g1", 32'(gnt), 32'h4);
        check("r2_s1", 32'(gnt_start), 32'h0);
        step(1);
        check("r2_gap", 32'(gnt), 32'h0);
        check("r2_gapbusy", 32'(busy), 32'h1);
        check("r2_gapid", 32'(gnt_id), 32'h2);
        step(1);
        check("r2_g2", 32'(gnt), 32'h4);
        check("r2_s2", 32'(gnt_start), 32'h1);

`ifndef ARB_PRIO0_EN
        // full rotation, 3-cycle slots
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            step(1);
            if (c % 3 == 2) begin
                check("rot_gap", 32'(gnt), 32'h0);
            end else begin
                check("rot_gnt", 32'(gnt), 32'(rot_seq[c / 3]));
                check("rot_start", 32'(gnt_start), (c % 3 == 0) ? 32'h1 : 32'h0);
            end
        end
`endif

        // early done
        do_reset();
        req = 4'b0010;
        step(1);
        check("dn_g0", 32'(gnt), 32'h2);
        done = 1'b1;
        step(1);
        check("dn_gap", 32'(gnt), 32'h0);
        check("dn_busy", 32'(busy), 32'h1);
        done = 1'b0;
        step(1);
        check("dn_g1", 32'(gnt), 32'h2);
        check("dn_s1", 32'(gnt_start), 32'h1);

        // owner 3 drops, scan wraps to 0
        do_reset();
        req = 4'b1000;
        step(1);
        check("wr_g3", 32'(gnt), 32'h8);
        check("wr_id3", 32'(gnt_id), 32'h3);
        req = 4'b0011;
        step(1);
        check("wr_gap", 32'(gnt), 32'h0);
        check("wr_gapid", 32'(gnt_id), 32'h3);
        step(1);
        check("wr_g0", 32'(gnt), 32'h1);

        // async reset mid-grant after ptr has moved to 3
        do_reset();
        req = 4'b0100;
        step(4);
        check("ar_pre", 32'(gnt), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check("ar_gnt", 32'(gnt), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1100;
        step(1);
        check("ar_post", 32'(gnt), 32'h4);

`ifdef ARB_PRIO0_EN
        do_reset();
        req = 4'b1111;
        for (int s = 0; s < 6; s++) begin
            step(1);
            check("prio_gnt", 32'(gnt), 32'(prio_seq[s]));
            step(2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
